alu_responder: RTL and testbench
================================

Name: alu_responder

Overview:
Responder end of the control-unit/ALU operand interface. It accepts one request at a time (opcode, operand 1, operand 2) over a valid/ready handshake and executes it over a defined number of cycles. It returns a registered result plus a 5-bit flag vector through a second valid/ready handshake. It sits between the control unit (initiator) and the LED/counter datapath, and replaces the free-running combinational ALU so the initiator no longer relies on fixed "wait" states.

Parameters:
WIDTH, 4, operand/result width in bits.
LATENCY, 1, extra execute cycles for single-cycle ops (legal range 0..7).

Ports:
clk  input  1  system clock, rising edge.
iReset  input  1  asynchronous, active-high reset.
iValid  input  1  request valid from initiator.
oReady  output  1  responder can accept a request.
iOpCode  input  4  operation select.
iDato_1  input  WIDTH  operand A.
iDato_2  input  WIDTH  operand B.
oValid  output  1  result/flags valid.
iReady  input  1  initiator accepts result.
oResult  output  WIDTH  result.
oFlags  output  5  [0] zero, [1] carry/borrow, [2] negative (result MSB), [3] signed overflow, [4] A<B unsigned.

Behaviour:
- Reset: asynchronous, active-high (iReset). All outputs go to 0 immediately (oReady=0, oValid=0, oResult=0, oFlags=0). State goes to IDLE. The first cycle after release shows oReady=1.
- States: IDLE, EXEC, DONE.
- IDLE: oReady=1. On iValid&&oReady at edge k:
  - latch iOpCode, iDato_1, iDato_2;
  - load the cycle counter;
  - go to EXEC.
- EXEC: oReady=0, oValid=0. Runs for N cycles, where N=WIDTH for MUL and N=LATENCY+1 for all other ops. oResult/oFlags are updated and oValid=1 from edge k+N, and the state goes to DONE.
- DONE: oValid=1; oResult/oFlags held stable. On iValid... no, on iReady=1 at an edge: oValid drops, state goes to IDLE, and oReady=1 in the following cycle. iValid is ignored in EXEC/DONE (no queuing).
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 XOR
  - 0011 NOT A
  - 0100 pass A
  - 0101 ADD A+B
  - 0110 SUB A-B
  - 0111 MUL (iterative shift-add, one partial product per EXEC cycle; oResult = low WIDTH bits)
  - 1000 SHL A by 1
  - 1001 SHR A by 1 (logical)
  - 1010..1111 illegal: result 0, flags 0 except zero=1
- Carry/borrow rules:
  - ADD: carry-out.
  - SUB: borrow (A<B).
  - MUL: 1 if the high WIDTH product bits are nonzero.
  - SHL: old MSB. SHR: old LSB.
  - All other ops: 0.
- Overflow: two's-complement overflow for ADD/SUB only; 0 otherwise.
- Flag [4]: computed from the latched operands for every legal op.
- Zero flag: result==0. After SUB it is the equality indication.
- Arithmetic wraps modulo 2^WIDTH (e.g. 15+1 gives 0).
- Reset asserted in EXEC or DONE aborts the operation; no stale result is presented after release.
- An opcode change on the inputs after acceptance has no effect, because operands are latched.

Optional Feature:
ALU_OP_COUNT_EN: when defined, the block adds output oOpCount (8 bits).
- Increments on each result handshake (oValid&&iReady); wraps 255 to 0; reset value 0.
- When undefined, the port and its counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then SUB A=9 B=9, LATENCY=1 -> oValid at accept+2 cycles; oResult=0000; oFlags=5'b00001.
- SUB A=3 B=9 -> oResult=1010; oFlags=5'b11110.
- ADD A=15 B=1 -> oResult=0000; oFlags=5'b00011.
- MUL A=6 B=7 (WIDTH=4) -> oValid exactly 4 cycles after accept; oResult=1010; oFlags=5'b10110. Then MUL 5x3 -> oResult=1111; oFlags=5'b00100.
- Back-pressure: hold iReady=0 for 5 cycles in DONE -> oValid stays 1, result stable, oReady=0, new iValid ignored. Raise iReady -> oReady=1 the next cycle.
- Reset mid-EXEC of a MUL -> outputs 0 immediately. After release oReady=1 and oValid=0. With ALU_OP_COUNT_EN, oOpCount=0 and reads 1 after the next completed op.

Source files
------------

// File: rtl/alu_responder_if.sv
// Operand/result handshake bundle between the control unit and the ALU.
// master = initiator (control unit), slave = responder (ALU).
interface alu_responder_if #(
    parameter int WIDTH = 4
);
    logic             iValid;
    logic             oReady;
    logic [3:0]       iOpCode;
    logic [WIDTH-1:0] iDato_1;
    logic [WIDTH-1:0] iDato_2;
    logic             oValid;
    logic             iReady;
    logic [WIDTH-1:0] oResult;
    logic [4:0]       oFlags;

    modport master (
        output iValid,
        output iOpCode,
        output iDato_1,
        output iDato_2,
        output iReady,
        input  oReady,
        input  oValid,
        input  oResult,
        input  oFlags
    );

    modport slave (
        input  iValid,
        input  iOpCode,
        input  iDato_1,
        input  iDato_2,
        input  iReady,
        output oReady,
        output oValid,
        output oResult,
        output oFlags
    );
endinterface

// File: rtl/alu_responder.sv
// Handshaked multi-cycle ALU responder (IDLE -> EXEC -> DONE).
// Optional ALU_OP_COUNT_EN adds an 8-bit completed-op counter oOpCount.
module alu_responder #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic           clk,
    input  logic           iReset,
    alu_responder_if.slave bus
`ifdef ALU_OP_COUNT_EN
    ,
    output logic [7:0]     oOpCount
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_NOT  = 4'b0011;
    localparam logic [3:0] OP_PASS = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;

    // Counter holds "remaining EXEC edges minus one".
    localparam logic [7:0] MUL_CNT = 8'(WIDTH - 1);
    localparam logic [7:0] OP_CNT  = 8'(LATENCY);

    logic [1:0]         state_q, state_d;
    logic               ready_q;
    logic               valid_q;
    logic [WIDTH-1:0]   res_q;
    logic [4:0]         flags_q;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [7:0]         cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;

    logic               accept;
    logic               last;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   res_d;
    logic [4:0]         flags_d;

    assign accept = (state_q == S_IDLE) && ready_q && bus.iValid;
    assign last   = (state_q == S_EXEC) && (cnt_q == 8'd0);

    // One shift-add partial product per EXEC cycle.
    assign prod_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    // Result and flags from the latched operands.
    always_comb begin
        logic carry;
        logic ovf;
        logic legal;
        res_d = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        legal = 1'b1;
        case (op_q)
            OP_AND:  res_d = a_q & b_q;
            OP_OR:   res_d = a_q | b_q;
            OP_XOR:  res_d = a_q ^ b_q;
            OP_NOT:  res_d = ~a_q;
            OP_PASS: res_d = a_q;
            OP_ADD: begin
                res_d = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                        (res_d[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                        (res_d[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_MUL: begin
                res_d = prod_d[WIDTH-1:0];
                carry = |prod_d[2*WIDTH-1:WIDTH];
            end
            OP_SHL: begin
                res_d = a_q << 1;
                carry = a_q[WIDTH-1];
            end
            OP_SHR: begin
                res_d = a_q >> 1;
                carry = a_q[0];
            end
            default: legal = 1'b0;
        endcase
        if (legal)
            flags_d = {a_q < b_q, ovf, res_d[WIDTH-1],
                       carry, res_d == '0};
        else
            flags_d = 5'b00001;
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_EXEC;
            S_EXEC: if (last) state_d = S_DONE;
            S_DONE: if (bus.iReady) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, handshake outputs and registered result.
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_IDLE);
            if (last) begin
                valid_q <= 1'b1;
                res_q   <= res_d;
                flags_q <= flags_d;
            end else if (state_q == S_DONE && bus.iReady) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Operand latch, cycle counter and multiplier datapath.
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (accept) begin
            op_q     <= bus.iOpCode;
            a_q      <= bus.iDato_1;
            b_q      <= bus.iDato_2;
            cnt_q    <= (bus.iOpCode == OP_MUL) ? MUL_CNT : OP_CNT;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, bus.iDato_1};
            mplier_q <= bus.iDato_2;
        end else if (state_q == S_EXEC) begin
            if (cnt_q != 8'd0)
                cnt_q <= cnt_q - 8'd1;
            if (op_q == OP_MUL) begin
                acc_q    <= prod_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
        end
    end

`ifdef ALU_OP_COUNT_EN
    logic [7:0] opcnt_q;

    // Count completed result handshakes; wraps naturally.
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset)
            opcnt_q <= 8'd0;
        else if (valid_q && bus.iReady)
            opcnt_q <= opcnt_q + 8'd1;
    end

    assign oOpCount = opcnt_q;
`endif

    assign bus.oReady  = ready_q;
    assign bus.oValid  = valid_q;
    assign bus.oResult = res_q;
    assign bus.oFlags  = flags_q;

endmodule

// File: tb/tb_alu_responder.sv
// Directed, table-driven bench for alu_responder (WIDTH=4, LATENCY=1).
// Define ALU_OP_COUNT_EN on both RTL and bench to check oOpCount.
module tb_alu_responder;

    logic clk = 1'b0;
    logic iReset;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    alu_responder_if #(.WIDTH(4)) bus ();

`ifdef ALU_OP_COUNT_EN
    logic [7:0] opcount;
    alu_responder #(.WIDTH(4), .LATENCY(1)) dut (
        .clk(clk),
        .iReset(iReset),
        .bus(bus),
        .oOpCount(opcount)
    );
`else
    alu_responder #(.WIDTH(4), .LATENCY(1)) dut (
        .clk(clk),
        .iReset(iReset),
        .bus(bus)
    );
`endif

    typedef struct {
        string    name;
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic [4:0] flg;
        int       lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Wait for oReady, accept one request, then wait for oValid.
    task automatic start_op(input string nm, input logic [3:0] op,
                            input logic [3:0] a, input logic [3:0] b,
                            input int lat);
        int n;
        int cyc;
        n = 0;
        @(negedge clk);
        while (!bus.oReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " ready_wait"}, 32'(bus.oReady), 32'd1);
        bus.iValid  = 1'b1;
        bus.iOpCode = op;
        bus.iDato_1 = a;
        bus.iDato_2 = b;
        @(posedge clk);
        #1;
        bus.iValid  = 1'b0;
        bus.iOpCode = 4'b0101;
        bus.iDato_1 = ~a;
        bus.iDato_2 = ~b;
        cyc = 0;
        while (!bus.oValid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({nm, " latency"}, 32'(cyc), 32'(lat));
    endtask

    // Complete the result handshake and check the return to IDLE.
    task automatic finish_op(input string nm);
        @(negedge clk);
        bus.iReady = 1'b1;
        @(posedge clk);
        #1;
        bus.iReady = 1'b0;
        chk({nm, " valid_drop"}, 32'(bus.oValid), 32'd0);
        chk({nm, " ready_back"}, 32'(bus.oReady), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{"sub_eq",  4'b0110, 4'd9,  4'd9,  4'b0000, 5'b00001, 2};
        vecs[1]  = '{"sub_neg", 4'b0110, 4'd3,  4'd9,  4'b1010, 5'b11110, 2};
        vecs[2]  = '{"add_wrap",4'b0101, 4'd15, 4'd1,  4'b0000, 5'b00011, 2};
        vecs[3]  = '{"mul_6x7", 4'b0111, 4'd6,  4'd7,  4'b1010, 5'b10110, 4};
        vecs[4]  = '{"mul_5x3", 4'b0111, 4'd5,  4'd3,  4'b1111, 5'b00100, 4};
        vecs[5]  = '{"and",     4'b0000, 4'd12, 4'd10, 4'b1000, 5'b00100, 2};
        vecs[6]  = '{"or",      4'b0001, 4'd5,  4'd2,  4'b0111, 5'b00000, 2};
        vecs[7]  = '{"xor",     4'b0010, 4'd9,  4'd9,  4'b0000, 5'b00001, 2};
        vecs[8]  = '{"not",     4'b0011, 4'd5,  4'd3,  4'b1010, 5'b00100, 2};
        vecs[9]  = '{"pass",    4'b0100, 4'd3,  4'd8,  4'b0011, 5'b10000, 2};
        vecs[10] = '{"shl",     4'b1000, 4'd9,  4'd0,  4'b0010, 5'b00010, 2};
        vecs[11] = '{"shr",     4'b1001, 4'd5,  4'd0,  4'b0010, 5'b00010, 2};
        vecs[12] = '{"illegal", 4'b1100, 4'd1,  4'd2,  4'b0000, 5'b00001, 2};
        vecs[13] = '{"add_ovf", 4'b0101, 4'd7,  4'd1,  4'b1000, 5'b01100, 2};

        iReset      = 1'b1;
        bus.iValid  = 1'b0;
        bus.iReady  = 1'b0;
        bus.iOpCode = '0;
        bus.iDato_1 = '0;
        bus.iDato_2 = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst oReady", 32'(bus.oReady), 32'd0);
        chk("rst oValid", 32'(bus.oValid), 32'd0);
        chk("rst oResult", 32'(bus.oResult), 32'd0);
        chk("rst oFlags", 32'(bus.oFlags), 32'd0);
        @(negedge clk);
        iReset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst oReady", 32'(bus.oReady), 32'd1);

        foreach (vecs[i]) begin
            start_op(vecs[i].name, vecs[i].op, vecs[i].a,
                     vecs[i].b, vecs[i].lat);
            chk({vecs[i].name, " result"},
                32'(bus.oResult), 32'(vecs[i].res));
            chk({vecs[i].name, " flags"},
                32'(bus.oFlags), 32'(vecs[i].flg));
            finish_op(vecs[i].name);
        end

        // Back-pressure: DONE holds, new requests are ignored.
        start_op("bp", 4'b0110, 4'd3, 4'd9, 2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.iValid  = 1'b1;
            bus.iOpCode = 4'b0000;
            bus.iDato_1 = 4'd0;
            bus.iDato_2 = 4'd0;
            @(posedge clk);
            #1;
            chk("bp oValid", 32'(bus.oValid), 32'd1);
            chk("bp oResult", 32'(bus.oResult), 32'b1010);
            chk("bp oFlags", 32'(bus.oFlags), 32'b11110);
            chk("bp oReady", 32'(bus.oReady), 32'd0);
        end
        bus.iValid = 1'b0;
        finish_op("bp");
        repeat (3) @(posedge clk);
        #1;
        chk("bp no_queue", 32'(bus.oValid), 32'd0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.iValid  = 1'b1;
        bus.iOpCode = 4'b0111;
        bus.iDato_1 = 4'd6;
        bus.iDato_2 = 4'd7;
        @(posedge clk);
        #1;
        bus.iValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        iReset = 1'b1;
        #1;
        chk("abort oReady", 32'(bus.oReady), 32'd0);
        chk("abort oValid", 32'(bus.oValid), 32'd0);
        chk("abort oResult", 32'(bus.oResult), 32'd0);
        chk("abort oFlags", 32'(bus.oFlags), 32'd0);
        @(negedge clk);
        iReset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort oReady_after", 32'(bus.oReady), 32'd1);
        chk("abort oValid_after", 32'(bus.oValid), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort no_stale", 32'(bus.oValid), 32'd0);
`ifdef ALU_OP_COUNT_EN
        chk("opcount reset", 32'(opcount), 32'd0);
`endif
        start_op("post_abort", 4'b0101, 4'd2, 4'd3, 2);
        chk("post_abort result", 32'(bus.oResult), 32'd5);
        chk("post_abort flags", 32'(bus.oFlags), 32'b10000);
        finish_op("post_abort");
`ifdef ALU_OP_COUNT_EN
        chk("opcount one", 32'(opcount), 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
